// File: rtl/gate_seq_pkg.sv
// Shared types, function codes and golden truth-table function for the
// four-input gate self-test sequencer.
package gate_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_CHECK  = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic [1:0] FUNC_NOR  = 2'd0;
   localparam logic [1:0] FUNC_NAND = 2'd1;
   localparam logic [1:0] FUNC_XOR  = 2'd2;
   localparam logic [1:0] FUNC_AND  = 2'd3;

   localparam int VEC_W = 4;
   localparam int CNT_W = 4;
   localparam int ERR_W = 5;

   // Expected gate output for a 4-bit input vector; XOR means odd parity.
   function automatic logic expected(input logic [1:0] func, input logic [VEC_W-1:0] vec);
      logic r;
      case (func)
         FUNC_NOR:  r = ~(|vec);
         FUNC_NAND: r = ~(&vec);
         FUNC_XOR:  r = ^vec;
         default:   r = &vec;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/gate_expected.sv
// Combinational golden model of the gate under test.
module gate_expected
   import gate_seq_pkg::*;
(
   input  logic [1:0]       i_func,
   input  logic [VEC_W-1:0] i_vec,
   output logic             o_exp
);

   assign o_exp = expected(i_func, i_vec);

endmodule

// File: rtl/four_input_gate_sequencer.sv
// Exhaustive self-test sequencer for a four-input gate: walks all 16 input
// vectors, waits a settle interval per vector, compares the gate output with
// the golden truth table and reports pass / mismatch count / first failure.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | waiting for start; results and last vector held
// ST_SETTLE | vector driven, settle counter running down to 0
// ST_CHECK  | sample gate_out, score it, advance or finish
// ST_DONE   | one-cycle done pulse, results valid
module four_input_gate_sequencer
   import gate_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int FUNC          = 0
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             gate_out,
   output logic             a,
   output logic             b,
   output logic             c,
   output logic             d,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] first_fail_vec,
   output logic             first_fail_valid
);

   localparam logic [CNT_W-1:0] LP_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [1:0]       LP_FUNC   = 2'(FUNC);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [VEC_W-1:0]   r_vec;
   logic [CNT_W-1:0]   r_cnt;
   logic [ERR_W-1:0]   r_err;
   logic               r_pass;
   logic [VEC_W-1:0]   r_ff_vec;
   logic               r_ff_valid;

   logic               w_exp;
   logic               w_launch;
   logic               w_check;
   logic               w_mismatch;
   logic               w_last;

   gate_expected u_expected (
      .i_func (LP_FUNC),
      .i_vec  (r_vec),
      .o_exp  (w_exp)
   );

   assign w_last = (r_vec == {VEC_W{1'b1}});

   // Next-state and per-cycle control strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_launch    = 1'b0;
      w_check     = 1'b0;
      w_mismatch  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_launch    = 1'b1;
               w_state_nxt = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            w_check     = 1'b1;
            w_mismatch  = (gate_out != w_exp);
            w_state_nxt = w_last ? ST_DONE : ST_SETTLE;
         end
         ST_DONE: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Vector register and settle down-counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vec <= '0;
         r_cnt <= '0;
      end else if (w_launch) begin
         r_vec <= '0;
         r_cnt <= LP_RELOAD;
      end else if (r_state == ST_SETTLE && r_cnt != '0) begin
         r_cnt <= r_cnt - 1'b1;
      end else if (w_check && !w_last) begin
         r_vec <= r_vec + 1'b1;
         r_cnt <= LP_RELOAD;
      end
   end

   // Result registers. pass is resolved on the final CHECK edge so that it is
   // already valid while done is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err      <= '0;
         r_pass     <= 1'b0;
         r_ff_vec   <= '0;
         r_ff_valid <= 1'b0;
      end else if (w_launch) begin
         r_err      <= '0;
         r_pass     <= 1'b0;
         r_ff_valid <= 1'b0;
      end else if (w_check) begin
         if (w_mismatch) begin
            r_err <= r_err + 1'b1;
            if (!r_ff_valid) begin
               r_ff_vec   <= r_vec;
               r_ff_valid <= 1'b1;
            end
         end
         if (w_last) begin
            r_pass <= (r_err == '0) && !w_mismatch;
         end
      end
   end

   assign a                = r_vec[3];
   assign b                = r_vec[2];
   assign c                = r_vec[1];
   assign d                = r_vec[0];
   assign busy             = (r_state != ST_IDLE);
   assign done             = (r_state == ST_DONE);
   assign pass             = r_pass;
   assign err_count        = r_err;
   assign first_fail_vec   = r_ff_vec;
   assign first_fail_valid = r_ff_valid;

endmodule

// File: tb/tb_four_input_gate_sequencer.sv
// Bench for four_input_gate_sequencer: four instances (one per gate function,
// each with a different settle interval) driven by a programmable truth table
// standing in for the gate under test.
module tb_four_input_gate_sequencer;

   localparam int SETS  [4] = '{2, 1, 3, 15};
   localparam int FUNCS [4] = '{0, 1, 2, 3};

   logic        clk;
   logic        rst;
   logic        start            [4];
   logic        gate_out         [4];
   logic        a                [4];
   logic        b                [4];
   logic        c                [4];
   logic        d                [4];
   logic        busy             [4];
   logic        done             [4];
   logic        pass             [4];
   logic [4:0]  err_count        [4];
   logic [3:0]  first_fail_vec   [4];
   logic        first_fail_valid [4];
   logic [15:0] tt               [4];

   int n_checks;
   int n_errors;

   four_input_gate_sequencer #(.SETTLE_CYCLES(2), .FUNC(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .gate_out(gate_out[0]),
      .a(a[0]), .b(b[0]), .c(c[0]), .d(d[0]), .busy(busy[0]), .done(done[0]),
      .pass(pass[0]), .err_count(err_count[0]), .first_fail_vec(first_fail_vec[0]),
      .first_fail_valid(first_fail_valid[0]));

   four_input_gate_sequencer #(.SETTLE_CYCLES(1), .FUNC(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .gate_out(gate_out[1]),
      .a(a[1]), .b(b[1]), .c(c[1]), .d(d[1]), .busy(busy[1]), .done(done[1]),
      .pass(pass[1]), .err_count(err_count[1]), .first_fail_vec(first_fail_vec[1]),
      .first_fail_valid(first_fail_valid[1]));

   four_input_gate_sequencer #(.SETTLE_CYCLES(3), .FUNC(2)) u_dut2 (
      .clk(clk), .rst(rst), .start(start[2]), .gate_out(gate_out[2]),
      .a(a[2]), .b(b[2]), .c(c[2]), .d(d[2]), .busy(busy[2]), .done(done[2]),
      .pass(pass[2]), .err_count(err_count[2]), .first_fail_vec(first_fail_vec[2]),
      .first_fail_valid(first_fail_valid[2]));

   four_input_gate_sequencer #(.SETTLE_CYCLES(15), .FUNC(3)) u_dut3 (
      .clk(clk), .rst(rst), .start(start[3]), .gate_out(gate_out[3]),
      .a(a[3]), .b(b[3]), .c(c[3]), .d(d[3]), .busy(busy[3]), .done(done[3]),
      .pass(pass[3]), .err_count(err_count[3]), .first_fail_vec(first_fail_vec[3]),
      .first_fail_valid(first_fail_valid[3]));

   // Emulated gate under test: a 16-entry truth table indexed by {a,b,c,d}.
   for (genvar g = 0; g < 4; g++) begin : g_gate
      assign gate_out[g] = tt[g][{a[g], b[g], c[g], d[g]}];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          k;
      logic [15:0] tt;
      int          restart;
      int          exp_err;
      int          exp_first;
   } vec_t;

   function automatic int vec_of(input int k);
      return int'({a[k], b[k], c[k], d[k]});
   endfunction

   // Reference gate behaviour from the number of ones in the vector.
   function automatic bit ref_bit(input int func, input int v);
      int ones;
      bit r;
      ones = 0;
      for (int i = 0; i < 4; i++) ones += (v >> i) & 1;
      case (func)
         0:       r = (ones == 0);
         1:       r = (ones != 4);
         2:       r = (ones % 2) == 1;
         default: r = (ones == 4);
      endcase
      return r;
   endfunction

   function automatic logic [15:0] good_tt(input int func);
      logic [15:0] t;
      t = '0;
      for (int v = 0; v < 16; v++) t[v] = ref_bit(func, v);
      return t;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Launch one run on instance k and check timing and results.
   task automatic run_check(input int k, input int restart, input int exp_err,
                            input int exp_first, input string tag);
      int n;
      int lat;
      int busy_bad;
      lat      = 1 + 16 * (SETS[k] + 1);
      busy_bad = 0;
      @(negedge clk);
      start[k] = 1'b1;
      @(negedge clk);
      start[k] = 1'b0;
      n = 1;
      chk({tag, " busy_c1"}, int'(busy[k]), 1);
      chk({tag, " vec_c1"}, vec_of(k), 0);
      chk({tag, " cleared_c1"}, int'({pass[k], err_count[k], first_fail_valid[k]}), 0);
      while (!done[k] && n < lat + 20) begin
         @(negedge clk);
         n++;
         start[k] = (n == restart);
         if (!busy[k]) busy_bad++;
      end
      start[k] = 1'b0;
      chk({tag, " done_latency"}, n, lat);
      chk({tag, " busy_through_run"}, busy_bad, 0);
      chk({tag, " err_count"}, int'(err_count[k]), exp_err);
      chk({tag, " pass"}, int'(pass[k]), int'(exp_err == 0));
      chk({tag, " first_valid"}, int'(first_fail_valid[k]), int'(exp_first >= 0));
      if (exp_first >= 0) chk({tag, " first_vec"}, int'(first_fail_vec[k]), exp_first);
      chk({tag, " vec_done"}, vec_of(k), 15);
      @(negedge clk);
      chk({tag, " done_pulse"}, int'({done[k], busy[k]}), 0);
      chk({tag, " err_hold"}, int'(err_count[k]), exp_err);
      chk({tag, " pass_hold"}, int'(pass[k]), int'(exp_err == 0));
      chk({tag, " vec_hold"}, vec_of(k), 15);
   endtask

   initial begin
      vec_t        tbl[11];
      logic [15:0] t;
      int          k;
      int          sel;
      int          e_err;
      int          e_first;

      tbl[0]  = '{0, 16'h0001, -1,  0, -1};
      tbl[1]  = '{0, 16'h0000, -1,  1,  0};
      tbl[2]  = '{0, 16'hFFFF, -1, 15,  1};
      tbl[3]  = '{2, 16'h0001, -1,  9,  0};
      tbl[4]  = '{0, 16'h0001, 16,  0, -1};
      tbl[5]  = '{1, 16'h7FFF, -1,  0, -1};
      tbl[6]  = '{1, 16'hFFFF, -1,  1, 15};
      tbl[7]  = '{3, 16'h0000, -1,  1, 15};
      tbl[8]  = '{3, 16'h8000, -1,  0, -1};
      tbl[9]  = '{2, 16'h6996, -1,  0, -1};
      tbl[10] = '{2, 16'h6997, -1,  1,  0};

      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         start[i] = 1'b0;
         tt[i]    = '0;
      end

      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset ctl%0d", i),
             int'({busy[i], done[i], pass[i], first_fail_valid[i]}), 0);
         chk($sformatf("reset data%0d", i),
             int'({err_count[i], first_fail_vec[i]}) + vec_of(i), 0);
      end
      rst = 1'b0;

      for (int i = 0; i < 11; i++) begin
         tt[tbl[i].k] = tbl[i].tt;
         run_check(tbl[i].k, tbl[i].restart, tbl[i].exp_err, tbl[i].exp_first,
                   $sformatf("tbl%0d", i));
      end

      // Asynchronous reset in the middle of vector 7, then a clean rerun.
      tt[0] = 16'hFFFF;
      @(negedge clk);
      start[0] = 1'b1;
      @(negedge clk);
      start[0] = 1'b0;
      repeat (21) @(negedge clk);
      chk("midrst vec_before", vec_of(0), 7);
      chk("midrst err_before", int'(err_count[0]), 6);
      chk("midrst first_before", int'({first_fail_valid[0], first_fail_vec[0]}), 17);
      #2 rst = 1'b1;
      #1;
      chk("midrst ctl", int'({busy[0], done[0], pass[0], first_fail_valid[0]}), 0);
      chk("midrst data", int'({err_count[0], first_fail_vec[0]}), 0);
      chk("midrst vec", vec_of(0), 0);
      @(negedge clk);
      rst = 1'b0;
      tt[0] = 16'h0001;
      run_check(0, -1, 0, -1, "after_rst");

      // Randomized truth tables scored against the reference model.
      for (int it = 0; it < 30; it++) begin
         k   = $urandom_range(0, 3);
         sel = $urandom_range(0, 2);
         t   = good_tt(FUNCS[k]);
         if (sel == 1) t[$urandom_range(0, 15)] ^= 1'b1;
         if (sel == 2) t ^= 16'($urandom);
         tt[k]   = t;
         e_err   = 0;
         e_first = -1;
         for (int v = 0; v < 16; v++) begin
            if (t[v] != ref_bit(FUNCS[k], v)) begin
               e_err++;
               if (e_first < 0) e_first = v;
            end
         end
         run_check(k, -1, e_err, e_first, $sformatf("rnd%0d", it));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
